// File: rtl/bp_pkg.sv
// bp_pkg: shared BytePipe definitions: FSM states, command-byte layout, field widths
package bp_pkg;
  localparam int BP_WNR_BIT = 7;
  localparam int BP_ADDR_W  = 7;
  localparam int BP_DATA_W  = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_SEND_DATA,
    ST_WAIT,
    ST_RESP
  } state_t;
  function automatic logic [BP_DATA_W-1:0] bp_cmd(input logic wr, input logic [BP_ADDR_W-1:0] addr);
    bp_cmd = '0;
    bp_cmd[BP_WNR_BIT] = wr;
    bp_cmd[BP_ADDR_W-1:0] = addr;
  endfunction
endpackage

// File: rtl/bp_reg_initiator.sv
// bp_reg_initiator: turns one register request into a BytePipe byte sequence and returns the reply byte
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cg                  clock gate; low holds every flop
//   i_req_*/o_req_ready   word request in (wr, 7b addr, 8b data); ready only in IDLE
//   o_rsp_*/i_rsp_ready   response out (reply byte, timeout error)
//   o_bp_*/i_bp_ready     BytePipe bytes to the responder
//   i_bp_*/o_bp_ready     BytePipe reply bytes from the responder; always sunk while clocked
module bp_reg_initiator
  import bp_pkg::*;
#(
  parameter bit RD_PRIME  = 1'b1,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [BP_ADDR_W-1:0] i_req_addr,
  input  logic [BP_DATA_W-1:0] i_req_data,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [BP_DATA_W-1:0] o_rsp_data,
  output logic                 o_rsp_err,
  output logic [BP_DATA_W-1:0] o_bp_data,
  output logic                 o_bp_valid,
  input  logic                 i_bp_ready,
  input  logic [BP_DATA_W-1:0] i_bp_data,
  input  logic                 i_bp_valid,
  output logic                 o_bp_ready
);
  state_t                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [BP_ADDR_W-1:0]   addr_q, addr_d;
  logic [BP_DATA_W-1:0]   wdata_q, wdata_d;
  logic                   prime_q, prime_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   bp_valid_q, bp_valid_d;
  logic [BP_DATA_W-1:0]   bp_data_q, bp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BP_DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [TIMEOUT_W-1:0]   cnt_inc;
  assign cnt_inc     = cnt_q + TIMEOUT_W'(1);
  assign o_req_ready = state_q == ST_IDLE;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_bp_valid  = bp_valid_q;
  assign o_bp_data   = bp_data_q;
  assign o_bp_ready  = i_cg;
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    prime_d     = prime_q;
    cnt_d       = '0;
    bp_valid_d  = bp_valid_q;
    bp_data_d   = bp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: if (i_req_valid) begin
        state_d    = ST_SEND_CMD;
        wr_d       = i_req_wr;
        addr_d     = i_req_addr;
        wdata_d    = i_req_data;
        prime_d    = RD_PRIME && !i_req_wr;
        bp_valid_d = 1'b1;
        bp_data_d  = bp_cmd(i_req_wr, i_req_addr);
      end
      ST_SEND_CMD: if (i_bp_ready) begin
        state_d    = wr_q ? ST_SEND_DATA : ST_WAIT;
        bp_valid_d = wr_q;
        bp_data_d  = wr_q ? wdata_q : '0;
      end
      ST_SEND_DATA: if (i_bp_ready) begin
        state_d    = ST_WAIT;
        bp_valid_d = 1'b0;
        bp_data_d  = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // a reply arriving on the saturating cycle still counts as a good reply
        if (i_bp_valid && prime_q) begin
          state_d    = ST_SEND_CMD;
          prime_d    = 1'b0;
          bp_valid_d = 1'b1;
          bp_data_d  = bp_cmd(wr_q, addr_q);
        end else if (i_bp_valid || cnt_inc == '1) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_bp_valid ? i_bp_data : '0;
          rsp_err_d   = !i_bp_valid;
        end
      end
      ST_RESP: if (i_rsp_ready) begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      prime_q     <= 1'b0;
      cnt_q       <= '0;
      bp_valid_q  <= 1'b0;
      bp_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (i_cg) begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      prime_q     <= prime_d;
      cnt_q       <= cnt_d;
      bp_valid_q  <= bp_valid_d;
      bp_data_q   <= bp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_bp_reg_initiator.sv
// tb_bp_reg_initiator: table-driven and scoreboard bench with a 128-byte BytePipe responder model
module tb_bp_reg_initiator;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cg = 1'b1;
  logic       i_req_valid = 1'b0;
  logic       i_req_wr = 1'b0;
  logic [6:0] i_req_addr = '0;
  logic [7:0] i_req_data = '0;
  logic       i_rsp_ready = 1'b0;
  logic       i_bp_ready = 1'b0;
  logic       i_bp_valid = 1'b0;
  logic [7:0] i_bp_data = '0;
  logic       o_req_ready, o_rsp_valid, o_rsp_err, o_bp_valid, o_bp_ready;
  logic [7:0] o_rsp_data, o_bp_data;

  bp_reg_initiator #(.RD_PRIME(1'b1), .TIMEOUT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
    .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  typedef struct { logic [7:0] d; logic e; } rsp_t;
  typedef struct { logic wr; logic [6:0] a; logic [7:0] d; logic [7:0] ed; } vec_t;
  rsp_t sb_q[$];
  vec_t tv[8];

  // responder model state
  logic [7:0] mem [128];
  logic [6:0] lat = '0;
  logic       dph = 1'b0;
  logic       hs = 1'b0;
  logic [7:0] hs_byte = '0;
  logic [7:0] rb = '0;
  logic       rv;
  int         stall_cnt = 0;
  logic       stall_next = 1'b0;
  logic       silent = 1'b0;
  logic       inject = 1'b0;
  logic [7:0] sent_q[$];

  initial foreach (mem[i]) mem[i] = 8'h00;

  always @(posedge i_clk) begin
    hs = o_bp_valid && i_bp_ready && i_cg && !i_rst;
    hs_byte = o_bp_data;
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      dph = 1'b0;
      stall_cnt = 0;
      i_bp_valid = 1'b0;
      i_bp_ready = 1'b0;
    end else begin
      rv = 1'b0;
      if (hs) begin
        sent_q.push_back(hs_byte);
        if (dph) begin
          mem[lat] = hs_byte;
          rb = mem[lat];
          rv = 1'b1;
          dph = 1'b0;
        end else if (hs_byte[7]) begin
          lat = hs_byte[6:0];
          dph = 1'b1;
          if (stall_next) begin
            stall_cnt = 10;
            stall_next = 1'b0;
          end
        end else begin
          rb = mem[lat];
          lat = hs_byte[6:0];
          rv = 1'b1;
        end
      end
      i_bp_valid = (rv && !silent) || inject;
      i_bp_data = inject ? 8'hEE : rb;
      inject = 1'b0;
      if (stall_cnt > 0) begin
        i_bp_ready = 1'b0;
        stall_cnt--;
      end else i_bp_ready = $urandom_range(0, 3) != 0;
    end
  end

  task automatic tick;
    @(negedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_req(input logic wr, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] ed, input logic ee, input logic push);
    int n = 0;
    i_req_wr = wr;
    i_req_addr = a;
    i_req_data = d;
    i_req_valid = 1'b1;
    while (!o_req_ready && n < 100) begin
      tick;
      n++;
    end
    chk("req_ready", o_req_ready, 1);
    tick;
    i_req_valid = 1'b0;
    if (push) sb_q.push_back('{ed, ee});
  endtask

  task automatic wait_rsp(input string nm, input int hold);
    int n = 0;
    rsp_t e = '{8'h00, 1'b0};
    while (!o_rsp_valid && n < 200) begin
      tick;
      n++;
    end
    chk({nm, "_valid"}, o_rsp_valid, 1);
    if (sb_q.size() == 0) chk({nm, "_sb_empty"}, 0, 1);
    else e = sb_q.pop_front();
    chk({nm, "_data"}, o_rsp_data, e.d);
    chk({nm, "_err"}, o_rsp_err, e.e);
    for (int k = 0; k < hold; k++) begin
      tick;
      chk({nm, "_hold"}, {o_rsp_valid, o_req_ready, o_rsp_data}, {1'b1, 1'b0, e.d});
    end
    i_rsp_ready = 1'b1;
    tick;
    i_rsp_ready = 1'b0;
    chk({nm, "_idle"}, {o_rsp_valid, o_req_ready}, 2'b01);
  endtask

  task automatic chk_bytes(input string nm, input logic [7:0] b0, input logic [7:0] b1);
    chk({nm, "_nbytes"}, sent_q.size(), 2);
    if (sent_q.size() == 2) begin
      chk({nm, "_byte0"}, sent_q[0], b0);
      chk({nm, "_byte1"}, sent_q[1], b1);
    end
    sent_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [7:0] cmd;
    tv[0] = '{1'b1, 7'h05, 8'hA5, 8'hA5};
    tv[1] = '{1'b0, 7'h05, 8'h00, 8'hA5};
    tv[2] = '{1'b1, 7'h7F, 8'h3C, 8'h3C};
    tv[3] = '{1'b1, 7'h00, 8'hFF, 8'hFF};
    tv[4] = '{1'b0, 7'h7F, 8'h00, 8'h3C};
    tv[5] = '{1'b0, 7'h00, 8'h00, 8'hFF};
    tv[6] = '{1'b1, 7'h05, 8'h5A, 8'h5A};
    tv[7] = '{1'b0, 7'h05, 8'h00, 8'h5A};

    i_rst = 1'b1;
    repeat (3) tick;
    chk("reset_ctl", {o_req_ready, o_bp_valid, o_rsp_valid, o_rsp_err}, 4'b1000);
    chk("reset_data", {o_bp_data, o_rsp_data}, 16'h0000);
    chk("reset_bp_ready", o_bp_ready, 1);
    i_rst = 1'b0;
    tick;

    inject = 1'b1;
    repeat (4) tick;
    chk("unsolicited", {o_rsp_valid, o_req_ready, o_bp_valid}, 3'b010);

    for (int i = 0; i < 8; i++) begin
      cmd = {tv[i].wr, tv[i].a};
      sent_q.delete();
      send_req(tv[i].wr, tv[i].a, tv[i].d, tv[i].ed, 1'b0, 1'b1);
      chk("cmd_out", {o_bp_valid, o_bp_data}, {1'b1, cmd});
      wait_rsp("tbl", 0);
      chk_bytes("tbl", cmd, tv[i].wr ? tv[i].d : cmd);
    end

    stall_next = 1'b1;
    sent_q.delete();
    send_req(1'b1, 7'h10, 8'hA5, 8'hA5, 1'b0, 1'b1);
    n = 0;
    while (stall_cnt == 0 && n < 100) begin
      tick;
      n++;
    end
    chk("stall_seen", stall_cnt != 0, 1);
    repeat (10) begin
      chk("stall_hold", {o_bp_valid, o_bp_data}, {1'b1, 8'hA5});
      tick;
    end
    wait_rsp("stall", 0);
    chk_bytes("stall", 8'h90, 8'hA5);

    send_req(1'b1, 7'h22, 8'h5C, 8'h5C, 1'b0, 1'b1);
    wait_rsp("rsp_hold", 5);
    sent_q.delete();

    send_req(1'b1, 7'h33, 8'hC3, 8'hC3, 1'b0, 1'b1);
    n = 0;
    while (!o_rsp_valid && n < 200) begin
      tick;
      n++;
    end
    i_cg = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (3) begin
      tick;
      chk("cg_hold", {o_rsp_valid, o_bp_ready}, 2'b10);
    end
    i_cg = 1'b1;
    i_rsp_ready = 1'b0;
    wait_rsp("cg", 0);
    sent_q.delete();

    silent = 1'b1;
    send_req(1'b0, 7'h05, 8'h00, 8'h00, 1'b1, 1'b1);
    n = 0;
    while (o_bp_valid && n < 100) begin
      tick;
      n++;
    end
    k = 0;
    while (!o_rsp_valid && k < 100) begin
      tick;
      k++;
    end
    chk("timeout_cycles", k, 15);
    wait_rsp("timeout", 0);
    chk("timeout_nbytes", sent_q.size(), 1);
    sent_q.delete();

    send_req(1'b0, 7'h20, 8'h00, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (o_bp_valid && n < 100) begin
      tick;
      n++;
    end
    repeat (3) tick;
    i_rst = 1'b1;
    tick;
    chk("rst_wait_ctl", {o_req_ready, o_bp_valid, o_rsp_valid, o_rsp_err}, 4'b1000);
    chk("rst_wait_data", {o_bp_data, o_rsp_data}, 16'h0000);
    i_rst = 1'b0;
    silent = 1'b0;
    k = 0;
    repeat (20) begin
      tick;
      if (o_rsp_valid) k++;
    end
    chk("rst_no_rsp", k, 0);
    sent_q.delete();

    send_req(1'b0, 7'h05, 8'h00, 8'h5A, 1'b0, 1'b1);
    wait_rsp("final", 0);
    chk_bytes("final", 8'h05, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
